// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, LSB first.
// One full-adder slice (two half-adder cells + OR) plus a carry flop;
// one operand bit per clock, WIDTH clocks per operation.
// Optional feature macro: SERIAL_ADD_SUB_OVERFLOW_EN adds a signed
// overflow output captured on the final bit step.

// Half-adder cell: the building block of the serial slice.
module serial_add_sub_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 sum bits already produced; the final bit is
  // concatenated on the last step, so no slot is wasted.
  logic [WIDTH-2:0] r_sh;
  logic [WIDTH-2:0] r_sh_nxt;
  logic             carry_ff;
  logic [CW-1:0]    count;

  // Full-adder slice built from two half-adder cells and an OR.
  logic s0, c0, s, c1, c;

  serial_add_sub_ha u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s0), .c(c0));
  serial_add_sub_ha u_ha1 (.x(s0),      .y(carry_ff), .s(s), .c(c1));

  assign c = c0 | c1;

  // Sum shift register: new bit enters at the MSB, older bits move down.
  generate
    if (WIDTH > 2) begin : g_rsh
      assign r_sh_nxt = {s, r_sh[WIDTH-2:1]};
    end else begin : g_rsh1
      assign r_sh_nxt = s;
    end
  endgenerate

  // Control FSM and datapath registers; rst wins over any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      carry_ff  <= 1'b0;
      count     <= '0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts start like IDLE so operations can run back-to-back.
          done <= 1'b0;
          if (start) begin
            a_sh     <= a;
            b_sh     <= sub ? ~b : b;
            carry_ff <= sub;      // the +1 of two's-complement subtraction
            count    <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          r_sh     <= r_sh_nxt;
          carry_ff <= c;
          count    <= count + 1'b1;
          if (count == LAST) begin
            result    <= {s, r_sh};
            carry_out <= c;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            // carry_ff is the carry into the MSB on this step.
            overflow  <= carry_ff ^ c;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub against
// a plain-arithmetic reference model. Define SERIAL_ADD_SUB_OVERFLOW_EN
// to also check the overflow output.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out;
  logic [W-1:0] result;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_res;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    .overflow(overflow),
`endif
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation starting at the current negedge and follow it to
  // done. poke>0 pulses start with a=AA at that busy cycle. Returns at the
  // negedge where done is high, so the next call lands in the DONE cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tsub, input int poke);
    int sa, sb, sr, ua, ub;
    int edges, nb;
    logic [W-1:0] exp_r;
    logic exp_c, exp_v;
    ua = int'(ta); ub = int'(tb_);
    sa = int'($signed(ta)); sb = int'($signed(tb_));
    if (tsub) begin
      exp_r = W'(ua - ub);
      exp_c = (ua >= ub);
      sr    = sa - sb;
    end else begin
      exp_r = W'(ua + ub);
      exp_c = (ua + ub) >= (1 << W);
      sr    = sa + sb;
    end
    exp_v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));

    a = ta; b = tb_; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    chk("busy_acc", {31'b0, busy}, 32'd1);
    chk("done_drop", {31'b0, done}, 32'd0);
    edges = 0; nb = 1;
    while (!done && edges < W + 4) begin
      if (poke > 0 && edges == poke - 1) begin
        start = 1'b1; a = 8'hAA;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
      if (busy) nb++;
    end
    start = 1'b0;
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", edges, W);
    chk("busy_cycles", nb, W);
    chk("result", {24'b0, result}, {24'b0, exp_r});
    chk("carry_out", {31'b0, carry_out}, {31'b0, exp_c});
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    chk("overflow", {31'b0, overflow}, {31'b0, exp_v});
`else
    if (exp_v) begin end
`endif
    last_res = exp_r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, dcnt;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(8'h35, 8'h4A, 1'b0, 0);
    @(negedge clk);
    chk("single_done", {31'b0, done}, 32'd0);
    chk("hold", {24'b0, result}, 32'h7F);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h10, 8'h20, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b1, 0);
    do_op(8'h00, 8'h00, 1'b1, 0);
    @(negedge clk);
    // Busy protection then back-to-back accept in the DONE cycle
    do_op(8'h01, 8'h02, 1'b0, 3);
    do_op(8'h05, 8'h05, 1'b0, 0);
    @(negedge clk);

    // Reset mid-operation
    a = 8'h0F; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", {24'b0, result}, 32'd0);
    chk("mid_rst_carry", {31'b0, carry_out}, 32'd0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 0);
    do_op(8'h0F, 8'h0F, 1'b0, 0);

    // Random sweep
    for (int i = 0; i < 500; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        @(negedge clk);
        chk("rnd_done_pulse", {31'b0, done}, 32'd0);
        chk("rnd_hold", {24'b0, result}, {24'b0, last_res});
        repeat (gap - 1) @(negedge clk);
      end
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
